// File: rtl/seg7_pkg.sv
// Shared types and constants for the multiplexed 7-segment driver.
// Segment vectors are active-low, bit6 = a ... bit0 = g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment code lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed NDIGITS x 7-segment driver with frame-synchronous double buffering.
// Optional per-digit blinking is compiled in with `define SEG7_BLINK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NDIGITS      = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [4*NDIGITS-1:0] data,
  input  logic [NDIGITS-1:0]   dig_en,
  input  logic                 lzb,
`ifdef SEG7_BLINK_EN
  input  logic [NDIGITS-1:0]   blink,
`endif
  output logic                 ack,
  output seg_t                 seg,
  output logic [NDIGITS-1:0]   an,
  output logic                 frame_tick
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);
  localparam logic [PW-1:0] LAST_CNT = PW'(SCAN_DIV - 1);

  if (NDIGITS < 1 || NDIGITS > 16 || SCAN_DIV < 2 || BLINK_FRAMES < 1) begin : g_param_check
    $error("seg7_scan_driver: parameter out of range");
  end

  logic [PW-1:0]            cnt;
  logic [IW-1:0]            idx;
  logic [NDIGITS-1:0][3:0]  stage;
  logic [NDIGITS-1:0][3:0]  disp;
  logic                     pending;
  logic                     slot_end;
  logic                     wrap;
  logic [NDIGITS-1:0]       lead_zero;
  logic [NDIGITS-1:0]       blink_hide;
  logic [NDIGITS-1:0]       sel;
  logic [3:0]               nibble;
  logic                     hide;
  seg_t                     code;

  assign slot_end = (cnt == LAST_CNT);
  assign wrap     = slot_end && (idx == LAST_IDX);

  // Scan timing: prescaler, digit index and frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // NOTE: the buffers are plain registers with a defined reset value, so the
  // first frame after reset shows zeros rather than whatever powered up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage   <= '0;
      disp    <= '0;
      pending <= 1'b0;
      ack     <= 1'b0;
    end else begin
      ack <= wrap && pending;
      // NOTE: non-blocking updates mean disp receives the pre-edge stage value
      // even when a new load is captured on the same wrap edge.
      if (wrap && pending) disp <= stage;
      if (load) begin
        stage   <= data;
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] LAST_FRAME = FW'(BLINK_FRAMES - 1);

  logic [FW-1:0] frame_cnt;
  logic          blink_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (wrap) begin
      if (frame_cnt == LAST_FRAME) begin
        frame_cnt <= '0;
        blink_on  <= !blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  assign blink_hide = blink_on ? '0 : blink;
`else
  assign blink_hide = '0;
`endif

  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred; the blocking running AND
  // walks from the top digit downwards.
  always_comb begin
    logic all_zero;
    lead_zero = '0;
    sel       = '0;
    all_zero  = 1'b1;
    for (int i = NDIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero && (disp[i] == 4'h0);
      lead_zero[i] = all_zero;
    end
    sel[idx] = 1'b1;
    nibble   = disp[idx];
    hide     = !dig_en[idx]
            || (lzb && (idx != '0) && lead_zero[idx])
            || blink_hide[idx];
  end

  seg7_hex_decode u_decode (
    .nibble (nibble),
    .seg    (code)
  );

  // Registered pin drivers; an enabled but blanked digit still has its an low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= hide ? SEG_BLANK : code;
      an  <= dig_en[idx] ? ~sel : '1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed plan scenarios plus random
// loads/enables against a frame-level reference model.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int SD    = 4;
  localparam int BF    = 2;
  localparam int FRAME = N * SD;

  localparam logic [6:0] SEG_CODE [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic           clk    = 1'b0;
  logic           rst_n  = 1'b0;
  logic           load   = 1'b0;
  logic           lzb    = 1'b0;
  logic [4*N-1:0] data   = '0;
  logic [N-1:0]   dig_en = '1;
`ifdef SEG7_BLINK_EN
  logic [N-1:0]   blink  = '0;
`endif
  logic           ack;
  logic           frame_tick;
  logic [6:0]     seg;
  logic [N-1:0]   an;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .NDIGITS      (N),
    .SCAN_DIV     (SD),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data       (data),
    .dig_en     (dig_en),
    .lzb        (lzb),
`ifdef SEG7_BLINK_EN
    .blink      (blink),
`endif
    .ack        (ack),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: edges since reset release, loads staged since the
  // last frame boundary, and the contents currently on display.
  int             k;
  logic [4*N-1:0] staged_q[$];
  logic [4*N-1:0] disp_m;

  function automatic bit upper_zero(input logic [4*N-1:0] v, input int i);
    for (int j = i; j < N; j++)
      if (v[4*j +: 4] != 4'h0) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: predict what the outputs hold after this edge, then compare.
  task automatic step();
    int         idx_pre;
    int         frame_pre;
    bit         hide;
    logic [6:0] exp_seg;
    logic [N-1:0] exp_an;
    logic [N-1:0] one;
    bit         exp_ack;
    bit         exp_tick;
    @(posedge clk);
    k++;
    idx_pre   = ((k - 1) / SD) % N;
    frame_pre = (k - 1) / FRAME;
    hide = !dig_en[idx_pre];
    if (lzb && idx_pre != 0 && upper_zero(disp_m, idx_pre)) hide = 1'b1;
`ifdef SEG7_BLINK_EN
    if (((frame_pre / BF) % 2) == 1 && blink[idx_pre]) hide = 1'b1;
`endif
    exp_seg = hide ? 7'b1111111 : SEG_CODE[disp_m[4*idx_pre +: 4]];
    one     = N'(1);
    exp_an  = dig_en[idx_pre] ? ~(one << idx_pre) : '1;
    exp_tick = (k % FRAME) == 0;
    exp_ack  = 1'b0;
    if (exp_tick && staged_q.size() > 0) begin
      exp_ack = 1'b1;
      disp_m  = staged_q[$];
      staged_q.delete();
    end
    if (load) staged_q.push_back(data);
    @(negedge clk);
    check($sformatf("seg k=%0d", k), 32'(seg), 32'(exp_seg));
    check($sformatf("an k=%0d", k), 32'(an), 32'(exp_an));
    check($sformatf("ack k=%0d", k), 32'(ack), 32'(exp_ack));
    check($sformatf("frame_tick k=%0d", k), 32'(frame_tick), 32'(exp_tick));
    if (frame_pre < 0) $display("unreachable");
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(input int p);
    for (int i = 0; i < FRAME && (k % FRAME) != p; i++) step();
  endtask

  task automatic pulse_load(input logic [4*N-1:0] v);
    load = 1'b1;
    data = v;
    step();
    load = 1'b0;
  endtask

  // Asserts reset mid-cycle and checks the asynchronous reset values.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    load = 1'b0;
    #1;
    check("rst seg", 32'(seg), 32'h7f);
    check("rst an", 32'(an), 32'hf);
    check("rst ack", 32'(ack), 32'h0);
    check("rst frame_tick", 32'(frame_tick), 32'h0);
    k = 0;
    staged_q.delete();
    disp_m = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    run(2 * FRAME);

    pulse_load(16'h1A3F);
    run(2 * FRAME);

    lzb = 1'b1;
    pulse_load(16'h0005);
    run(2 * FRAME);
    pulse_load(16'h0000);
    run(2 * FRAME);
    lzb = 1'b0;

    run_to_phase(5);
    pulse_load(16'h1111);
    run(4);
    pulse_load(16'h2222);
    run(2 * FRAME);

    run_to_phase(3);
    pulse_load(16'h9876);
    run_to_phase(FRAME - 1);
    pulse_load(16'h4321);
    run(3 * FRAME);

    run_to_phase(6);
    pulse_load(16'hBEEF);
    run(3);
    do_reset();
    run(2 * FRAME);

`ifdef SEG7_BLINK_EN
    blink = 4'b0001;
    do_reset();
    pulse_load(16'h5678);
    run(7 * FRAME);
    blink = '0;
`endif

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        load = 1'b1;
        data = 16'($urandom) >> (4 * $urandom_range(0, 4));
      end else begin
        load = 1'b0;
      end
      if ($urandom_range(0, 49) == 0) begin
        dig_en = ($urandom_range(0, 2) == 0) ? 4'($urandom) : '1;
        lzb    = 1'($urandom);
`ifdef SEG7_BLINK_EN
        blink  = 4'($urandom);
`endif
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else step();
    end
    load = 1'b0;
    run(FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multi-digit, time-multiplexed 7-segment display driver. It takes NDIGITS hex nibbles and drives one shared active-low segment bus plus one active-low digit-select line per digit. It refreshes one digit per scan slot. It supports frame-synchronous double-buffered loads with an acknowledge, per-digit enable, leading-zero blanking and optional per-digit blinking. It sits between the core's display registers and the board's multiplexed 7-segment pins.

## Interface
- NDIGITS, 8, number of digits scanned (1..16)
- SCAN_DIV, 50000, clk cycles per digit slot (≥2)
- BLINK_FRAMES, 64, frames per blink half-period (used only with SEG7_BLINK_EN)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- load  in  1  request to stage `data`
- data  in  4*NDIGITS  hex nibbles; digit i = data[4i+3:4i], digit 0 least significant
- dig_en  in  NDIGITS  per-digit enable; 0 = digit dark
- lzb  in  1  leading-zero blanking enable
- blink  in  NDIGITS  per-digit blink select (present only with SEG7_BLINK_EN)
- ack  out  1  one-cycle pulse when staged data becomes visible
- seg  out  7  segments, active-low, bit6 = a … bit0 = g
- an  out  NDIGITS  digit select, active-low, one-hot-low or all-high
- frame_tick  out  1  one-cycle pulse when the scan index wraps to 0

## Operation
- Segment encoding uses active-low codes in the order a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0001100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
  - Blank = 1111111.
- Prescaler counts 0..SCAN_DIV-1. At the terminal count, idx advances to (idx+1) mod NDIGITS. frame_tick pulses when idx wraps from NDIGITS-1 to 0.
- Load staging:
  - `load`=1 captures `data` into the staging register and sets `pending`.
  - A new load while pending overwrites the staging register; the last value wins.
- Apply:
  - On the wrap edge with pending=1, the staging register is copied to the display buffer, pending clears and ack pulses in the same cycle as frame_tick.
  - If load and apply fall on the same edge, the pre-edge staging value is applied, the new data is staged, and pending stays 1.
- Digit i is blanked (seg=1111111) if any of the following holds:
  - dig_en[i]=0, in which case an[i] also stays high;
  - lzb=1, i≠0, and digits NDIGITS-1..i are all zero in the display buffer;
  - blink off-phase with blink[i]=1.
- Digit 0 is never leading-zero blanked.
- Only one an bit is low at any time. An enabled digit whose segments are blanked still gets its an bit driven low.

## Timing
- Reset values:
  - seg=1111111, an=all 1s, ack=0, frame_tick=0;
  - idx=0, prescaler=0, display buffer=0, staging=0, pending=0, blink phase=on.
- seg/an are registered and reflect idx one cycle after idx changes.
- A full frame takes NDIGITS×SCAN_DIV cycles.
- Latency from load to visible output:
  - minimum: 1 cycle to the wrap edge, +1 cycle output register;
  - maximum: NDIGITS×SCAN_DIV+1 cycles.
- Reset asserted mid-frame returns all state to reset values immediately. Any pending load is lost.
- Changes on dig_en and lzb take effect on the next output register update, with no frame alignment.

## Configuration
- SEG7_BLINK_EN defined:
  - `blink` port exists.
  - A frame counter toggles the blink phase every BLINK_FRAMES frame_ticks, starting in the on-phase.
  - In the off-phase, digits with blink[i]=1 are blanked.
- SEG7_BLINK_EN undefined:
  - No `blink` port and no frame counter.
  - BLINK_FRAMES is ignored.
  - Behaviour equals the blink phase held permanently at on.

## Structure
- Package seg7_pkg holds:
  - the 16-entry hex segment code constant array;
  - SEG_BLANK = 7'b1111111;
  - a typedef for the 7-bit segment vector.
- Sub-module seg7_hex_decode: a combinational 4-bit→7-bit lookup from seg7_pkg. It is instantiated once, on the muxed nibble.

## Test plan
- Reset: NDIGITS=4, SCAN_DIV=4, rst_n low → seg=1111111, an=1111; after release, idx walks with an=1110,1101,1011,0111 every 4 cycles.
- Load 0x1A3F with all digits enabled and lzb=0 → ack coincides with the next frame_tick; then seg shows F=0111000, 3=0000110, A=0001000, 1=1001111 on digits 0..3.
- Load 0x0005 with lzb=1 → digits 3..1 blanked (seg=1111111, an still low), digit 0 shows 0100100. Load 0x0000 → digit 0 shows 0000001.
- Load 0x1111 mid-frame, then 0x2222 before the wrap → a single ack, and 0x2222 displayed.
- Load on the exact wrap edge → the previous staging value is applied, pending stays 1, and a second ack arrives on the following frame_tick.
- SEG7_BLINK_EN with BLINK_FRAMES=2 and blink=0001 → digit 0 is blanked for frames 2–3 and visible for frames 0–1 and 4–5; other digits are unaffected.
